// File: rtl/ibus_resp_model.sv
// In-order responder for the VexRiscv simple iBus: each accepted fetch answers exactly LATENCY cycles later.
// Up to DEPTH commands in flight; cmd_ready drops when full or stalled. Responses cannot be back-pressured.
module ibus_resp_model #(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               DEPTH     = 4,
  parameter int               LATENCY   = 2,
  parameter int               MEM_WORDS = 1024,
  parameter bit               ERR_EN    = 1'b0,
  parameter logic [ADDR_W-1:0] ERR_BASE = 32'hF000_0000,
  parameter logic [ADDR_W-1:0] ERR_MASK = 32'hF000_0000,
  localparam int              BYTES     = DATA_W / 8,
  localparam int              OFS       = $clog2(BYTES),
  localparam int              MW_W      = $clog2(MEM_WORDS),
  localparam int              CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_payload_address,
  input  logic [2:0]        cmd_payload_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_payload_data,
  output logic              rsp_payload_error,
  input  logic              stall,
  input  logic              mem_we,
  input  logic [MW_W-1:0]   mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  outstanding
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam logic [AGE_W-1:0] AGE_DUE = AGE_W'(LATENCY - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);
  localparam logic [ADDR_W:0]  LIMIT   = (ADDR_W + 1)'(64'(MEM_WORDS) * 64'(BYTES));

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic [MW_W-1:0]   idx_q [DEPTH];
  logic              err_q [DEPTH];
  logic [AGE_W-1:0]  age_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept, retire, cmd_err;
  logic [MW_W-1:0]   cmd_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full queue blocks accepts even on a retiring cycle, so ready never looks at retire.
  assign cmd_ready = reset && !stall && (cnt_q < CNT_W'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign retire    = (cnt_q != '0) && (age_q[rd_ptr_q] == AGE_DUE);

  assign cmd_idx = cmd_payload_address[OFS +: MW_W];
  assign cmd_err = (cmd_payload_size != 3'(OFS))
                || (cmd_payload_address[OFS-1:0] != '0)
                || ({1'b0, cmd_payload_address} >= LIMIT)
                || (ERR_EN && ((cmd_payload_address & ERR_MASK) == ERR_BASE));

  always_comb begin
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d    = cnt_d + CNT_W'(1);
    end
    if (retire) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      cnt_d       = cnt_d - CNT_W'(1);
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_q[rd_ptr_q];
      rsp_data_d  = err_q[rd_ptr_q] ? '0 : mem_q[idx_q[rd_ptr_q]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (wr_ptr_q == PTR_W'(i))) begin
          age_q[i] <= '0;
        end else if (age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q[wr_ptr_q] <= cmd_idx;
      err_q[wr_ptr_q] <= cmd_err;
    end
  end

  // Backing array survives reset; a write on the retire edge lands after the response read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rsp_valid         = rsp_valid_q;
  assign rsp_payload_data  = rsp_data_q;
  assign rsp_payload_error = rsp_err_q;
  assign outstanding       = cnt_q;

  assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_W'(DEPTH));
  assert property (@(posedge clk) !reset |=> !rsp_valid_q);

endmodule
